fetch_pc_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the execute stage.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake, tolerating variable memory latency.
- Presents the fetched instruction and PC+4 to decode/execute, then resolves the next PC from the execute stage's branch-address, zero and jump results.
- Supports `beq`/`bne`, `j`, `jal`, `jr` and downstream stalls.

---
 rtl/minisys_pkg.sv | 14 +
 rtl/next_pc_sel.sv | 40 ++++
 rtl/fetch_pc_unit.sv | 110 +++++++++++
 tb/tb_fetch_pc_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/minisys_pkg.sv
// rtl/minisys_pkg.sv - shared fetch-stage types and constants
package minisys_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } fetch_state_e;

    localparam logic [5:0]  OP_J             = 6'h02;
    localparam logic [5:0]  OP_JAL           = 6'h03;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - combinational next-PC priority mux
// Ports:
//   pc_plus_4_i     sequential successor of the current PC
//   instr_target_i  26-bit j/jal target field
//   addr_result_i   branch target from execute
//   rs_data_i       jr target (low two bits forced to zero)
//   zero_i          execute compare result
//   branch_i, nbranch_i, jmp_i, jal_i, jr_i  decoded control
//   next_pc_o       selected next PC
module next_pc_sel (
    input  logic [31:0] pc_plus_4_i,
    input  logic [25:0] instr_target_i,
    input  logic [31:0] addr_result_i,
    input  logic [31:0] rs_data_i,
    input  logic        zero_i,
    input  logic        branch_i,
    input  logic        nbranch_i,
    input  logic        jmp_i,
    input  logic        jal_i,
    input  logic        jr_i,
    output logic [31:0] next_pc_o
);

    logic take_branch;

    assign take_branch = (branch_i & zero_i) | (nbranch_i & ~zero_i);

    always_comb begin
        next_pc_o = pc_plus_4_i;
        if (jr_i) begin
            // Word-align the register target rather than trapping on misalignment.
            next_pc_o = rs_data_i & ~32'h0000_0003;
        end else if (jmp_i || jal_i) begin
            next_pc_o = {pc_plus_4_i[31:28], instr_target_i, 2'b00};
        end else if (take_branch) begin
            next_pc_o = addr_result_i;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC owner and instruction fetch over req/ack
// Ports:
//   clock, reset        clock and async active-low reset
//   Addr_result, Zero, Read_data_1, Branch, nBranch, Jmp, Jal, Jr
//                       execute-stage results and decoded control
//   stall_in            downstream hold of the instruction in execute
//   imem_rdata, imem_ack, imem_req, imem_addr   instruction memory port
//   Instruction, PC_plus_4, link_addr, Inst_valid   outputs to decode/execute
module fetch_pc_unit
    import minisys_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = PC_RESET_DEFAULT,
    parameter int          ROM_ADDR_W = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           Addr_result,
    input  logic                  Zero,
    input  logic [31:0]           Read_data_1,
    input  logic                  Branch,
    input  logic                  nBranch,
    input  logic                  Jmp,
    input  logic                  Jal,
    input  logic                  Jr,
    input  logic                  stall_in,
    input  logic [31:0]           imem_rdata,
    input  logic                  imem_ack,
    output logic                  imem_req,
    output logic [ROM_ADDR_W-1:0] imem_addr,
    output logic [31:0]           Instruction,
    output logic [31:0]           PC_plus_4,
    output logic [31:0]           link_addr,
    output logic                  Inst_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  link_q, link_d;
    logic [31:0]  pc_plus_4;
    logic [31:0]  next_pc;
    logic         commit;

    assign pc_plus_4 = pc_q + 32'd4;
    assign commit    = (state_q == S_EXEC) && !stall_in;

    next_pc_sel u_next_pc_sel (
        .pc_plus_4_i    (pc_plus_4),
        .instr_target_i (instr_q[25:0]),
        .addr_result_i  (Addr_result),
        .rs_data_i      (Read_data_1),
        .zero_i         (Zero),
        .branch_i       (Branch),
        .nbranch_i      (nBranch),
        .jmp_i          (Jmp),
        .jal_i          (Jal),
        .jr_i           (Jr),
        .next_pc_o      (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        link_d  = link_q;
        unique case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                // Acks are only honoured while requesting, so stale acks are dropped.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (commit) begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                    if (Jal) begin
                        link_d = pc_plus_4;
                    end
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_RESET;
            pc_q    <= PC_RESET;
            instr_q <= 32'd0;
            link_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            link_q  <= link_d;
        end
    end

    // Decoded straight from state so reset drops the request without waiting for a clock.
    assign imem_req    = (state_q == S_FETCH);
    assign Inst_valid  = (state_q == S_EXEC);
    assign imem_addr   = pc_q[ROM_ADDR_W+1:2];
    assign Instruction = instr_q;
    assign PC_plus_4   = pc_plus_4;
    assign link_addr   = link_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;
    import minisys_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Addr_result = '0;
    logic        Zero = 1'b0;
    logic [31:0] Read_data_1 = '0;
    logic        Branch = 1'b0, nBranch = 1'b0, Jmp = 1'b0, Jal = 1'b0, Jr = 1'b0;
    logic        stall_in = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic        imem_req;
    logic [13:0] imem_addr;
    logic [31:0] Instruction, PC_plus_4, link_addr;
    logic        Inst_valid;

    int checks = 0;
    int failures = 0;

    fetch_pc_unit #(.PC_RESET(32'h0000_0000), .ROM_ADDR_W(14)) dut (
        .clock(clock), .reset(reset),
        .Addr_result(Addr_result), .Zero(Zero), .Read_data_1(Read_data_1),
        .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr),
        .stall_in(stall_in), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .imem_req(imem_req), .imem_addr(imem_addr), .Instruction(Instruction),
        .PC_plus_4(PC_plus_4), .link_addr(link_addr), .Inst_valid(Inst_valid)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Leaves the bench on a negedge with imem_req high, or reports a timeout.
    task automatic wait_req();
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (imem_req !== 1'b1) check_eq("req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    // Serves one fetch after lat wait cycles; returns how many cycles req was seen high.
    task automatic fetch(input logic [31:0] data, input int lat, output int req_cycles);
        wait_req();
        req_cycles = 0;
        repeat (lat) begin
            if (imem_req) req_cycles++;
            @(negedge clock);
        end
        if (imem_req) req_cycles++;
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clock);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic commit(input logic br, input logic nbr, input logic z, input logic jp,
                          input logic jl, input logic jrr, input logic [31:0] ar,
                          input logic [31:0] rs);
        Branch = br; nBranch = nbr; Zero = z; Jmp = jp; Jal = jl; Jr = jrr;
        Addr_result = ar; Read_data_1 = rs;
        @(negedge clock);
        Branch = 0; nBranch = 0; Zero = 0; Jmp = 0; Jal = 0; Jr = 0;
        Addr_result = 32'hFFFF_FFF0; Read_data_1 = 32'hFFFF_FFF0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=0x00000001 exp=0x00000000");
        $fatal(1, "timeout");
    end

    initial begin
        int rc;
        int vcnt;
        int unstable;

        repeat (3) @(negedge clock);
        check_eq("rst_instr",  Instruction, 32'h0);
        check_eq("rst_pc4",    PC_plus_4, 32'h4);
        check_eq("rst_link",   link_addr, 32'h0);
        check_eq("rst_valid",  {31'd0, Inst_valid}, 32'd0);
        check_eq("rst_req",    {31'd0, imem_req}, 32'd0);

        // Reset release: S_RESET cycle, then fetch with ack in the first fetch cycle.
        reset = 1'b1;
        @(negedge clock);
        check_eq("f0_req",   {31'd0, imem_req}, 32'd1);
        check_eq("f0_addr",  {18'd0, imem_addr}, 32'd0);
        check_eq("f0_valid", {31'd0, Inst_valid}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h2001_0005;
        @(negedge clock);
        imem_ack = 1'b0;
        check_eq("f0_ivalid", {31'd0, Inst_valid}, 32'd1);
        check_eq("f0_instr",  Instruction, 32'h2001_0005);
        check_eq("f0_pc4",    PC_plus_4, 32'h4);
        check_eq("f0_reqlow", {31'd0, imem_req}, 32'd0);
        commit(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check_eq("seq_addr", {18'd0, imem_addr}, 32'd1);

        // PC = 4: beq taken
        fetch(32'h1000_0010, 0, rc);
        commit(1, 0, 1, 0, 0, 0, 32'h40, 32'h0);
        check_eq("beq_taken", {18'd0, imem_addr}, 32'd16);
        // PC = 0x40: beq not taken
        fetch(32'h1000_0010, 0, rc);
        commit(1, 0, 0, 0, 0, 0, 32'h80, 32'h0);
        check_eq("beq_nt", {18'd0, imem_addr}, 32'd17);
        // PC = 0x44: bne not taken (Zero=1)
        fetch(32'h1400_0010, 0, rc);
        commit(0, 1, 1, 0, 0, 0, 32'h200, 32'h0);
        check_eq("bne_nt", {18'd0, imem_addr}, 32'd18);
        // PC = 0x48: bne taken to 0x100
        fetch(32'h1400_0010, 0, rc);
        commit(0, 1, 0, 0, 0, 0, 32'h100, 32'h0);
        check_eq("bne_taken", {18'd0, imem_addr}, 32'd64);

        // PC = 0x100: jal with target 0x080 -> 0x200
        fetch({OP_JAL, 26'h0000_080}, 0, rc);
        check_eq("jal_pc4", PC_plus_4, 32'h104);
        commit(0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
        check_eq("jal_addr", {18'd0, imem_addr}, 32'd128);
        check_eq("jal_link", link_addr, 32'h104);

        // PC = 0x200: Jr beats Branch, low bits cleared
        fetch(32'h03E0_0008, 0, rc);
        commit(1, 0, 1, 0, 0, 1, 32'h80, 32'h37);
        check_eq("jr_addr", {18'd0, imem_addr}, 32'd13);
        check_eq("jr_pc4",  PC_plus_4, 32'h38);
        check_eq("jr_link", link_addr, 32'h104);

        // PC = 0x34: j to 0x40 keeps link_addr
        fetch({OP_J, 26'h0000_010}, 0, rc);
        commit(0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
        check_eq("j_addr", {18'd0, imem_addr}, 32'd16);
        check_eq("j_link", link_addr, 32'h104);

        // PC = 0x40: latency 3 plus a 4-cycle stall starting as Inst_valid rises
        fetch(32'hABCD_1234, 3, rc);
        check_eq("lat_req_cycles", rc, 32'd4);
        stall_in = 1'b1;
        vcnt = 0;
        unstable = 0;
        repeat (4) begin
            if (Inst_valid) vcnt++;
            if (Instruction !== 32'hABCD_1234 || PC_plus_4 !== 32'h44 ||
                imem_addr !== 14'd16 || imem_req !== 1'b0) unstable++;
            @(negedge clock);
        end
        stall_in = 1'b0;
        if (Inst_valid) vcnt++;
        @(negedge clock);
        check_eq("stall_valid_cycles", vcnt, 32'd5);
        check_eq("stall_stable", unstable, 32'd0);
        check_eq("stall_adv_once", {18'd0, imem_addr}, 32'd17);

        // Reset mid-fetch at PC 0x44, with a late ack straddling release
        @(negedge clock);
        check_eq("mid_req", {31'd0, imem_req}, 32'd1);
        reset = 1'b0;
        #1;
        check_eq("async_req_drop", {31'd0, imem_req}, 32'd0);
        check_eq("rst2_instr", Instruction, 32'h0);
        check_eq("rst2_pc4",   PC_plus_4, 32'h4);
        check_eq("rst2_link",  link_addr, 32'h0);
        @(negedge clock);
        imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
        reset = 1'b1;
        @(negedge clock);
        imem_ack = 1'b0;
        check_eq("late_ack_valid", {31'd0, Inst_valid}, 32'd0);
        check_eq("late_ack_instr", Instruction, 32'h0);
        check_eq("restart_addr",   {18'd0, imem_addr}, 32'd0);
        fetch(32'h2001_0005, 0, rc);
        check_eq("restart_instr", Instruction, 32'h2001_0005);
        check_eq("restart_valid", {31'd0, Inst_valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
